obf_seq: RTL and testbench

Substep sequencer for the hardware obfuscator: sits between IF and ID, takes each fetched instruction plus its instruction-group index (IGU), and walks the obfuscation LUT one substep per cycle. Each substep's LUT entry is composed with the original instruction to emit one replacement instruction to ID. Fetch stalls until the entry flagged "last" has been issued. The LUT is external and combinational; this block drives its address and consumes its output.

---
 rtl/obf_seq_if.sv | 29 ++
 rtl/obf_seq.sv | 120 ++++++++++++
 tb/tb_obf_seq.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/obf_seq_if.sv
// IF/ID/LUT-side bundle of the obfuscation substep sequencer.
// Valid/ready: a fetched insn transfers when if_valid=1, id_freeze=0, flush=0
// and the sequencer is idle. A high if_stall means hold if_insn for another
// cycle. id_valid qualifies id_insn and both hold while id_freeze is high.
interface obf_seq_if #(
  parameter int IGU_WIDTH  = 7,
  parameter int SUB_WIDTH  = 3,
  parameter int TYPE_WIDTH = 2
);
  logic                           if_valid;
  logic [31:0]                    if_insn;
  logic [IGU_WIDTH-1:0]           igu_idx;
  logic                           if_stall;
  logic                           id_freeze;
  logic [31:0]                    id_insn;
  logic                           id_valid;
  logic [IGU_WIDTH+SUB_WIDTH-1:0] lut_addr;
  logic [TYPE_WIDTH+16:0]         lut_out;

  modport master (
    output if_valid, if_insn, igu_idx, id_freeze, lut_out,
    input  if_stall, id_insn, id_valid, lut_addr
  );

  modport slave (
    input  if_valid, if_insn, igu_idx, id_freeze, lut_out,
    output if_stall, id_insn, id_valid, lut_addr
  );
endinterface

// File: rtl/obf_seq.sv
// Obfuscation substep sequencer: expands each fetched insn into one or more
// replacement insns by walking the external LUT one substep per cycle.
module obf_seq #(
  parameter int IGU_WIDTH  = 7,
  parameter int SUB_WIDTH  = 3,
  parameter int TYPE_WIDTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 obf_en,
  input  logic                 flush,
  obf_seq_if.slave             bus,
  output logic                 o_dbg_run,
  output logic [SUB_WIDTH-1:0] o_dbg_sub
);

  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

  localparam logic [TYPE_WIDTH-1:0] T_A = TYPE_WIDTH'(1);
  localparam logic [TYPE_WIDTH-1:0] T_S = TYPE_WIDTH'(2);
  localparam logic [31:0]           L_NOP = 32'h1500_0000;

  state_t                r_state;
  logic [31:0]           r_insn;
  logic [IGU_WIDTH-1:0]  r_igu;
  logic [SUB_WIDTH-1:0]  r_sub;
  logic [31:0]           r_id_insn;
  logic                  r_id_valid;

  logic [TYPE_WIDTH+16:0] w_entry;
  logic [TYPE_WIDTH-1:0]  w_type;
  logic [15:0]            w_tmpl;
  logic                   w_last;
  logic [31:0]            w_src;
  logic [4:0]             w_rd;
  logic [4:0]             w_ra;
  logic [4:0]             w_rb;
  logic [31:0]            w_emit;
  logic                   w_end;
  logic                   w_done;
  logic                   w_accept;
  logic                   w_idle;

  assign w_idle  = (r_state == ST_IDLE);
  // Bypass forces a single pass-through substep that always ends the sequence.
  assign w_entry = obf_en ? bus.lut_out : {{TYPE_WIDTH{1'b0}}, 16'h0000, 1'b1};
  assign w_type  = w_entry[TYPE_WIDTH+16 -: TYPE_WIDTH];
  assign w_tmpl  = w_entry[16:1];
  assign w_last  = w_entry[0];

  assign w_src = w_idle ? bus.if_insn : r_insn;
  assign w_rd  = w_tmpl[7] ? 5'd0 : w_src[25:21];
  assign w_ra  = w_tmpl[6] ? 5'd0 : w_src[20:16];
  assign w_rb  = w_tmpl[5] ? 5'd0 : w_src[15:11];

  assign w_emit = (w_type == T_A)
                ? {6'h38, w_rd, w_ra, w_rb, 1'b0, w_tmpl[13:12], 4'b0000, w_tmpl[11:8]}
                : w_src;

  // Only A and S can continue; N and the reserved code always end.
  assign w_end    = w_last | ~((w_type == T_A) | (w_type == T_S));
  assign w_done   = w_end | (~w_idle & (r_sub == {SUB_WIDTH{1'b1}}));
  assign w_accept = w_idle & bus.if_valid & ~bus.id_freeze & ~flush;

  assign bus.if_stall = ~flush & (w_idle ? (w_accept & ~w_done)
                                         : (bus.id_freeze | ~w_done));
  assign bus.lut_addr = w_idle ? {bus.igu_idx, {SUB_WIDTH{1'b0}}} : {r_igu, r_sub};
  assign bus.id_insn  = r_id_insn;
  assign bus.id_valid = r_id_valid;

  assign o_dbg_run = (r_state == ST_RUN);
  assign o_dbg_sub = r_sub;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_insn     <= 32'h0;
      r_igu      <= '0;
      r_sub      <= '0;
      r_id_insn  <= L_NOP;
      r_id_valid <= 1'b0;
    end else if (flush) begin
      r_state    <= ST_IDLE;
      r_sub      <= '0;
      r_id_valid <= 1'b0;
    end else if (!bus.id_freeze) begin
      case (r_state)
        ST_IDLE: begin
          if (bus.if_valid) begin
            r_insn     <= bus.if_insn;
            r_igu      <= bus.igu_idx;
            r_id_insn  <= w_emit;
            r_id_valid <= 1'b1;
            if (!w_done) begin
              r_state <= ST_RUN;
              r_sub   <= SUB_WIDTH'(1);
            end
          end else begin
            r_id_valid <= 1'b0;
          end
        end
        ST_RUN: begin
          r_id_insn  <= w_emit;
          r_id_valid <= 1'b1;
          if (w_done) begin
            r_state <= ST_IDLE;
            r_sub   <= '0;
          end else begin
            r_sub <= r_sub + SUB_WIDTH'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_sub   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_obf_seq.sv
// Bench for obf_seq: directed scenarios plus randomized insns checked against
// a substep-list model built from the LUT contents held here.
module tb_obf_seq;
  localparam int IW = 7;
  localparam int SW = 3;
  localparam int TW = 2;
  localparam int AW = IW + SW;
  localparam int LW = TW + 17;

  logic          clk = 1'b0;
  logic          rst;
  logic          obf_en;
  logic          flush;
  logic          dbg_run;
  logic [SW-1:0] dbg_sub;

  obf_seq_if #(.IGU_WIDTH(IW), .SUB_WIDTH(SW), .TYPE_WIDTH(TW)) bus ();

  logic [LW-1:0] lut_mem [0:(1<<AW)-1];
  assign bus.lut_out = lut_mem[bus.lut_addr];

  obf_seq #(.IGU_WIDTH(IW), .SUB_WIDTH(SW), .TYPE_WIDTH(TW)) dut (
    .clk       (clk),
    .rst       (rst),
    .obf_en    (obf_en),
    .flush     (flush),
    .bus       (bus),
    .o_dbg_run (dbg_run),
    .o_dbg_sub (dbg_sub)
  );

  // clock / reset
  always #5 clk = ~clk;

  logic [31:0] exp_q[$];
  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk = n_chk + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [LW-1:0] mk_entry(input logic [1:0] typ, input logic [7:0] func,
                                             input logic [2:0] zs, input logic last);
    return {typ, func, zs, 5'b00000, last};
  endfunction

  // Reference: list every replacement insn the sequencer should emit.
  function automatic int build_seq(input logic [31:0] insn, input logic [IW-1:0] igu,
                                   input logic en);
    logic [LW-1:0] e;
    logic [SW-1:0] s3;
    int unsigned   typ, func, zs, rd, ra, rb;
    logic [31:0]   o;
    for (int s = 0; s < 8; s++) begin
      s3 = SW'(s);
      e  = en ? lut_mem[{igu, s3}] : mk_entry(2'd0, 8'h00, 3'b000, 1'b1);
      typ  = 32'(e[18:17]);
      func = 32'(e[16:9]);
      zs   = 32'(e[8:6]);
      if (typ == 1) begin
        rd = ((zs / 4) % 2 == 1) ? 0 : 32'(insn[25:21]);
        ra = ((zs / 2) % 2 == 1) ? 0 : 32'(insn[20:16]);
        rb = (zs % 2 == 1)       ? 0 : 32'(insn[15:11]);
        o  = 32'(32'h38 * 32'h0400_0000 + rd * 32'h20_0000 + ra * 32'h1_0000 + rb * 32'h800
                 + ((func / 16) % 4) * 256 + (func % 16));
      end else begin
        o = insn;
      end
      exp_q.push_back(o);
      if (e[0] == 1'b1 || typ == 0 || typ == 3) return s + 1;
    end
    return 8;
  endfunction

  // driver: present one insn and follow its whole sequence
  task automatic run_insn(input logic [31:0] insn, input logic [IW-1:0] igu, input logic en);
    int k;
    logic [AW-1:0] a;
    obf_en        = en;
    bus.if_valid  = 1'b1;
    bus.if_insn   = insn;
    bus.igu_idx   = igu;
    k = build_seq(insn, igu, en);
    #1;
    a = {igu, 3'd0};
    chk("addr_sub0", 32'(bus.lut_addr), 32'(a));
    chk("stall_sub0", 32'(bus.if_stall), 32'(k > 1));
    for (int i = 0; i < k; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("emit_valid", 32'(bus.id_valid), 32'd1);
      chk("emit_insn", bus.id_insn, exp_q.pop_front());
      if (i < k - 1) begin
        a = {igu, SW'(i + 1)};
        chk("addr_run", 32'(bus.lut_addr), 32'(a));
        chk("stall_run", 32'(bus.if_stall), 32'(i + 1 < k - 1));
      end
    end
  endtask

  task automatic idle_cycle();
    bus.if_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("idle_valid", 32'(bus.id_valid), 32'd0);
    chk("idle_stall", 32'(bus.if_stall), 32'd0);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [IW-1:0] igu_r;
    int            pick;
    for (int i = 0; i < (1 << AW); i++) lut_mem[i] = mk_entry(2'd0, 8'h00, 3'b000, 1'b1);
    lut_mem[{7'd64, 3'd0}] = mk_entry(2'd1, 8'h00, 3'b101, 1'b0);
    lut_mem[{7'd64, 3'd1}] = mk_entry(2'd1, 8'h01, 3'b010, 1'b0);
    lut_mem[{7'd64, 3'd2}] = mk_entry(2'd1, 8'h05, 3'b111, 1'b1);
    for (int s = 0; s < 8; s++) lut_mem[{7'd10, SW'(s)}] = mk_entry(2'd2, 8'h00, 3'b000, 1'b0);
    for (int g = 20; g < 28; g++)
      for (int s = 0; s < 8; s++)
        lut_mem[{IW'(g), SW'(s)}] = mk_entry(2'($urandom_range(0, 3)), 8'($urandom),
                                             3'($urandom), $urandom_range(0, 3) == 0);

    // reset
    rst = 1'b1; flush = 1'b0; obf_en = 1'b1;
    bus.if_valid = 1'b0; bus.if_insn = 32'h0; bus.igu_idx = 7'd5; bus.id_freeze = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(bus.id_valid), 32'd0);
    chk("rst_insn", bus.id_insn, 32'h1500_0000);
    chk("rst_stall", 32'(bus.if_stall), 32'd0);
    chk("rst_addr", 32'(bus.lut_addr), 32'(10'h028));
    chk("rst_run", 32'(dbg_run), 32'd0);
    rst = 1'b0;

    // passthrough, three-step l.add back-to-back, bypass, runaway
    run_insn(32'h9C21_0004, 7'd3, 1'b1);
    run_insn(32'hE064_2800, 7'd64, 1'b1);
    run_insn(32'h9C21_0004, 7'd3, 1'b1);
    idle_cycle();
    run_insn(32'hE064_2800, 7'd64, 1'b0);
    run_insn($urandom, 7'd10, 1'b1);
    chk("runaway_idle", 32'(dbg_run), 32'd0);
    idle_cycle();

    // freeze mid-sequence
    obf_en = 1'b1; bus.if_valid = 1'b1; bus.if_insn = 32'hE064_2800; bus.igu_idx = 7'd64;
    step();
    chk("frz_first", bus.id_insn, 32'hE004_0000);
    bus.id_freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("frz_hold_insn", bus.id_insn, 32'hE004_0000);
      chk("frz_hold_valid", 32'(bus.id_valid), 32'd1);
      chk("frz_sub", 32'(dbg_sub), 32'd1);
      chk("frz_stall", 32'(bus.if_stall), 32'd1);
    end
    bus.id_freeze = 1'b0;
    step();
    chk("frz_resume", bus.id_insn, 32'hE060_2801);
    step();
    chk("frz_last", bus.id_insn, 32'hE000_0005);
    chk("frz_done", 32'(dbg_run), 32'd0);
    // freeze while idle with a valid insn: nothing captured, outputs held
    bus.if_insn = 32'h9C21_0004; bus.igu_idx = 7'd3; bus.id_freeze = 1'b1;
    #1 chk("frz_idle_stall", 32'(bus.if_stall), 32'd0);
    step();
    chk("frz_idle_insn", bus.id_insn, 32'hE000_0005);
    chk("frz_idle_valid", 32'(bus.id_valid), 32'd1);
    bus.id_freeze = 1'b0;
    idle_cycle();

    // flush mid-sequence, then flush on an accept cycle
    bus.if_valid = 1'b1; bus.if_insn = 32'hE064_2800; bus.igu_idx = 7'd64;
    step();
    chk("fl_first", bus.id_insn, 32'hE004_0000);
    flush = 1'b1;
    #1 chk("fl_stall", 32'(bus.if_stall), 32'd0);
    step();
    flush = 1'b0;
    chk("fl_valid", 32'(bus.id_valid), 32'd0);
    chk("fl_run", 32'(dbg_run), 32'd0);
    chk("fl_sub", 32'(dbg_sub), 32'd0);
    run_insn(32'h9C21_0004, 7'd3, 1'b1);
    flush = 1'b1; bus.if_insn = 32'hE064_2800; bus.igu_idx = 7'd64;
    step();
    flush = 1'b0;
    chk("fl_accept_valid", 32'(bus.id_valid), 32'd0);
    chk("fl_accept_run", 32'(dbg_run), 32'd0);

    // randomized insns
    for (int n = 0; n < 60; n++) begin
      pick = $urandom_range(0, 10);
      igu_r = (pick == 0) ? 7'd3 : (pick == 1) ? 7'd10 : (pick == 2) ? 7'd64
            : IW'(20 + $urandom_range(0, 7));
      run_insn($urandom, igu_r, $urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0) idle_cycle();
    end
    idle_cycle();
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
